// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Start/busy/done handshake; results are registered and only change on completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    count;
    logic             bin;
    logic             a_msb;
    logic             b_msb;

    logic             a0;
    logic             b0;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] r_next;

    // Full-subtractor cell on the current LSBs and the next result shift value
    always_comb begin
        a0     = a_sh[0];
        b0     = b_sh[0];
        d      = a0 ^ b0 ^ bin;
        bout   = (~a0 & b0) | (~(a0 ^ b0) & bin);
        r_next = {d, r_sh[WIDTH-1:1]};
    end

    // Control FSM, shift datapath and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            count    <= '0;
            bin      <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        bin   <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end
                end
                StShift: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    bin   <= bout;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        // r_next[WIDTH-1] is the result MSB produced on this edge
                        diff     <= r_next;
                        borrow   <= bout;
                        overflow <= (a_msb != b_msb) & (r_next[WIDTH-1] != a_msb);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        count    <= '0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operands against an
// arithmetic reference model, handshake timing, back-to-back and async-reset behaviour.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] last_diff;
    logic         last_borrow;
    logic         last_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int ux, uy, sx, sy, sd;
        ux = int'(x);
        uy = int'(y);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        sd = sx - sy;
        d  = W'((ux - uy) & ((1 << W) - 1));
        bo = (ux < uy);
        ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_diff_hold"}, 32'(diff), 32'(last_diff));
        check({tag, "_borrow_hold"}, 32'(borrow), 32'(last_borrow));
        check({tag, "_ovf_hold"}, 32'(overflow), 32'(last_ovf));
    endtask

    // One operation with a one-cycle start pulse; optionally pulse start again mid-operation
    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit glitch);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        model(x, y, ed, eb, eo);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_accept"}, 32'(busy), 32'd1);
        check({tag, "_done_accept"}, 32'(done), 32'd0);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            #1;
            if (glitch && i == 1) begin
                start = 1'b1;
                a     = '0;
                b     = W'(1);
            end else begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            if (i < W) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_done_early"}, 32'(done), 32'd0);
                check_held(tag);
            end else begin
                check({tag, "_done"}, 32'(done), 32'd1);
                check({tag, "_busy_end"}, 32'(busy), 32'd0);
                check({tag, "_diff"}, 32'(diff), 32'(ed));
                check({tag, "_borrow"}, 32'(borrow), 32'(eb));
                check({tag, "_ovf"}, 32'(overflow), 32'(eo));
                last_diff   = ed;
                last_borrow = eb;
                last_ovf    = eo;
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_clear"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check_held(tag);
    endtask

    // start held high: a new operation is accepted on the edge after each done
    task automatic back_to_back(input int n);
        logic [W-1:0] x, y, ed;
        logic         eb, eo;
        x = W'($urandom);
        y = W'($urandom);
        model(x, y, ed, eb, eo);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        check("b2b_busy_first", 32'(busy), 32'd1);
        for (int j = 0; j < n; j++) begin
            for (int i = 1; i <= W; i++) begin
                @(posedge clk);
                #1;
                if (i < W) begin
                    check("b2b_done_early", 32'(done), 32'd0);
                    check_held("b2b");
                end else begin
                    check("b2b_done", 32'(done), 32'd1);
                    check("b2b_diff", 32'(diff), 32'(ed));
                    check("b2b_borrow", 32'(borrow), 32'(eb));
                    check("b2b_ovf", 32'(overflow), 32'(eo));
                    last_diff   = ed;
                    last_borrow = eb;
                    last_ovf    = eo;
                    if (j < n - 1) begin
                        x = W'($urandom);
                        y = W'($urandom);
                        a = x;
                        b = y;
                        model(x, y, ed, eb, eo);
                    end else begin
                        start = 1'b0;
                    end
                end
            end
            if (j < n - 1) begin
                @(posedge clk);
                #1;
                check("b2b_reaccept_busy", 32'(busy), 32'd1);
                check("b2b_reaccept_done", 32'(done), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        check("b2b_final_done_clear", 32'(done), 32'd0);
        check("b2b_final_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        last_diff   = '0;
        last_borrow = 1'b0;
        last_ovf    = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", 32'(borrow), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op("t1", 4'b0110, 4'b0011, 1'b0);
        do_op("t2a", 4'b0001, 4'b0010, 1'b0);
        do_op("t2b", 4'b1000, 4'b0001, 1'b0);
        do_op("t3a", 4'b0111, 4'b1111, 1'b0);
        do_op("t3b", 4'b0101, 4'b0101, 1'b0);
        do_op("t4", 4'b1100, 4'b0010, 1'b1);
        // Ignored start must not have queued a second operation
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            check("t4_no_second_done", 32'(done), 32'd0);
            check("t4_no_second_busy", 32'(busy), 32'd0);
        end

        for (int k = 0; k < 20; k++) begin
            do_op("rand", W'($urandom), W'($urandom), 1'b0);
        end

        back_to_back(6);

        // Async reset in the middle of an operation
        do_op("pre_rst", 4'b1100, 4'b0010, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 4'b1011;
        b     = 4'b0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_diff", 32'(diff), 32'd0);
        check("rst_mid_borrow", 32'(borrow), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        last_diff   = '0;
        last_borrow = 1'b0;
        last_ovf    = 1'b0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            check("rst_no_done", 32'(done), 32'd0);
            check("rst_no_busy", 32'(busy), 32'd0);
        end
        do_op("t6", 4'b1110, 4'b0001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
